// File: rtl/avmm_pkg.sv
// rtl/avmm_pkg.sv - shared widths and response pipeline entry type
// Contents:
//   DATA_W      data bus width (32)
//   BE_W        byteenable width (4), one bit per data byte lane
//   rsp_entry_t one response pipeline slot: valid strobe plus read word
package avmm_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/avmm_mem_responder_if.sv
// rtl/avmm_mem_responder_if.sv - memory-mapped command/response bundle
// Signals:
//   address, read, write, byteenable, writedata : command, driven by master
//   readdata, readdatavalid                     : read response, driven by slave
//   waitrequest                                 : command stall, driven by slave
//   err                                         : sticky protocol-violation flag
interface avmm_mem_responder_if;
  import avmm_pkg::*;

  logic [31:0]       address;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;
  logic              err;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest, err
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest, err
  );

endinterface

// File: rtl/avmm_rsp_pipe.sv
// rtl/avmm_rsp_pipe.sv - fixed-length valid/data shift register for read responses
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   in_entry    slot entering the pipe (valid marks an accepted read)
//   out_entry   slot leaving the pipe LATENCY cycles later
// Only the valid bits are reset, so a reset drops every in-flight response
// while the data lanes stay free of reset logic.
module avmm_rsp_pipe
  import avmm_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  rsp_entry_t in_entry,
  output rsp_entry_t out_entry
);

  logic [LATENCY-1:0] valid_sr;
  logic [DATA_W-1:0]  data_sr [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr <= '0;
    end else begin
      valid_sr[0] <= in_entry.valid;
      for (int i = 1; i < LATENCY; i++) begin
        valid_sr[i] <= valid_sr[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    data_sr[0] <= in_entry.data;
    for (int i = 1; i < LATENCY; i++) begin
      data_sr[i] <= data_sr[i-1];
    end
  end

  assign out_entry = '{valid: valid_sr[LATENCY-1], data: data_sr[LATENCY-1]};

endmodule

// File: rtl/avmm_mem_responder.sv
// rtl/avmm_mem_responder.sv - memory-mapped word memory slave with pipelined reads
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         slave side of avmm_mem_responder_if
// Parameters:
//   DEPTH_LOG2  log2 of the number of 32-bit words
//   LATENCY     cycles from read acceptance to readdatavalid (1..8)
//   MAX_PENDING reads allowed in flight (1..LATENCY)
//   WAIT_CYCLES forced wait states inserted before each command (0..7)
module avmm_mem_responder
  import avmm_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int LATENCY     = 2,
  parameter int MAX_PENDING = 2,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  avmm_mem_responder_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  unused_addr_bits;

  logic                  cmd_present;
  logic                  wait_stall;
  logic                  full;
  logic                  waitrequest;
  logic                  accept;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  conflict;
  logic [2:0]            wait_cnt;
  logic [CNT_W-1:0]      inflight;
  logic                  err_q;
  rsp_entry_t            pipe_in;
  rsp_entry_t            pipe_out;

  // Upper address bits are dropped so out-of-range addresses wrap.
  assign word_idx         = bus.address[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{bus.address[31:DEPTH_LOG2+2], bus.address[1:0]};

  assign cmd_present = bus.read | bus.write;

  generate
    if (WAIT_CYCLES == 0) begin : g_no_wait
      assign wait_stall = 1'b0;
    end else begin : g_wait
      assign wait_stall = cmd_present && (wait_cnt < 3'(WAIT_CYCLES));
    end
  endgenerate

  // Full is judged on the registered count, so a response retiring in the
  // same cycle does not open a slot until the following cycle.
  assign full        = (inflight == CNT_W'(MAX_PENDING));
  assign waitrequest = !rst_n || wait_stall || (bus.read && full);
  assign accept      = cmd_present && !waitrequest;
  assign wr_acc      = accept && bus.write;
  assign rd_acc      = accept && bus.read && !bus.write;
  assign conflict    = accept && bus.read && bus.write;

  // Wait counter only advances while the wait-state rule is the one stalling;
  // a stall caused purely by the full condition holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!cmd_present || accept) begin
      wait_cnt <= '0;
    end else if (wait_stall) begin
      wait_cnt <= wait_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({rd_acc, pipe_out.valid})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (conflict) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.byteenable[i]) begin
          mem[word_idx][8*i +: 8] <= bus.writedata[8*i +: 8];
        end
      end
    end
  end

  // The pipe's first stage registers the array word at the accepting edge,
  // so the read sees every write accepted in earlier cycles.
  assign pipe_in = '{valid: rd_acc, data: mem[word_idx]};

  avmm_rsp_pipe #(
    .LATENCY (LATENCY)
  ) u_rsp_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_entry  (pipe_in),
    .out_entry (pipe_out)
  );

  assign bus.readdata      = pipe_out.data;
  assign bus.readdatavalid = pipe_out.valid;
  assign bus.waitrequest   = waitrequest;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_avmm_mem_responder.sv
// tb/tb_avmm_mem_responder.sv - directed self-checking bench for avmm_mem_responder
module tb_avmm_mem_responder;

  logic clk;
  logic rst_n;
  int   cyc;
  int   passed;
  int   total;

  logic [2:0]  rd_v;
  logic [2:0]  wr_v;
  logic [31:0] addr_v [3];
  logic [3:0]  be_v   [3];
  logic [31:0] wd_v   [3];
  logic [2:0]  wreq;
  logic [2:0]  rdv;
  logic [2:0]  errv;
  logic [31:0] rdat   [3];

  typedef struct {
    int          d;
    int          cyc;
    logic [31:0] data;
  } rsp_t;

  rsp_t rsp_q[$];

  avmm_mem_responder_if bus0 ();
  avmm_mem_responder_if bus1 ();
  avmm_mem_responder_if bus2 ();

  assign bus0.read = rd_v[0];  assign bus0.write = wr_v[0];  assign bus0.address = addr_v[0];
  assign bus0.byteenable = be_v[0];  assign bus0.writedata = wd_v[0];
  assign bus1.read = rd_v[1];  assign bus1.write = wr_v[1];  assign bus1.address = addr_v[1];
  assign bus1.byteenable = be_v[1];  assign bus1.writedata = wd_v[1];
  assign bus2.read = rd_v[2];  assign bus2.write = wr_v[2];  assign bus2.address = addr_v[2];
  assign bus2.byteenable = be_v[2];  assign bus2.writedata = wd_v[2];

  assign wreq = {bus2.waitrequest, bus1.waitrequest, bus0.waitrequest};
  assign rdv  = {bus2.readdatavalid, bus1.readdatavalid, bus0.readdatavalid};
  assign errv = {bus2.err, bus1.err, bus0.err};
  assign rdat[0] = bus0.readdata;
  assign rdat[1] = bus1.readdata;
  assign rdat[2] = bus2.readdata;

  avmm_mem_responder #(.DEPTH_LOG2(10), .LATENCY(2), .MAX_PENDING(2), .WAIT_CYCLES(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  avmm_mem_responder #(.DEPTH_LOG2(10), .LATENCY(4), .MAX_PENDING(2), .WAIT_CYCLES(0))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  avmm_mem_responder #(.DEPTH_LOG2(10), .LATENCY(2), .MAX_PENDING(2), .WAIT_CYCLES(3))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rdv[i]) rsp_q.push_back('{i, cyc, rdat[i]});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one command, waits out waitrequest (bounded), returns the number
  // of stalled cycles and the acceptance cycle; leaves the bus idle.
  task automatic issue(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] dat,
                       output int stalls, output int acc);
    rd_v[d] = r; wr_v[d] = w; addr_v[d] = a; be_v[d] = b; wd_v[d] = dat;
    stalls = 0;
    #1;
    while (wreq[d] && stalls < 50) begin
      @(posedge clk); #1;
      stalls++;
    end
    check("accept_within_bound", 32'(wreq[d]), 32'd0);
    acc = cyc;
    @(posedge clk); #1;
    rd_v[d] = 1'b0; wr_v[d] = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input int d, input int acc,
                            input logic [31:0] data, input int lat);
    rsp_t r;
    check({tag, "_present"}, 32'(rsp_q.size() != 0), 32'd1);
    if (rsp_q.size() != 0) begin
      r = rsp_q.pop_front();
      check({tag, "_dut"}, 32'(r.d), 32'(d));
      check({tag, "_latency"}, 32'(r.cyc - acc), 32'(lat));
      check({tag, "_data"}, r.data, data);
    end
  endtask

  initial begin
    int st, ac, ac1, ac2, ac3;
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    rd_v   = '0;
    wr_v   = '0;
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = '0; be_v[i] = '0; wd_v[i] = '0;
    end

    idle(3);
    check("reset_waitrequest", 32'(wreq), 32'h7);
    check("reset_readdatavalid", 32'(rdv), 32'h0);
    check("reset_err", 32'(errv), 32'h0);
    rst_n = 1'b1;

    // LATENCY=2 write then read, first command right after reset
    issue(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, st, ac);
    check("first_cmd_no_stall", 32'(st), 32'd0);
    issue(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, st, ac);
    idle(4);
    expect_rsp("rd_0x10", 0, ac, 32'hDEADBEEF, 2);

    // Byte-lane merge, byteenable=0 writes nothing
    issue(0, 1'b0, 1'b1, 32'h4, 4'hF, 32'hFFFFFFFF, st, ac);
    issue(0, 1'b0, 1'b1, 32'h4, 4'h3, 32'h00001234, st, ac);
    issue(0, 1'b0, 1'b1, 32'h4, 4'h0, 32'h00000000, st, ac);
    issue(0, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0, st, ac);
    idle(4);
    expect_rsp("rd_lanes", 0, ac, 32'hFFFF1234, 2);

    // Back-to-back reads give back-to-back responses in order
    issue(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, st, ac1);
    issue(0, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0, st, ac2);
    check("b2b_no_stall", 32'(ac2 - ac1), 32'd1);
    idle(4);
    expect_rsp("b2b_first", 0, ac1, 32'hDEADBEEF, 2);
    expect_rsp("b2b_second", 0, ac2, 32'hFFFF1234, 2);

    // Aliased address
    issue(0, 1'b1, 1'b0, 32'h1010, 4'h0, 32'h0, st, ac);
    idle(4);
    expect_rsp("rd_alias", 0, ac, 32'hDEADBEEF, 2);

    // read and write together: write lands, read dropped, err sticky
    check("err_clear_before", 32'(errv[0]), 32'd0);
    issue(0, 1'b1, 1'b1, 32'h8, 4'hF, 32'h00000055, st, ac);
    idle(5);
    check("conflict_no_rsp", 32'(rsp_q.size()), 32'd0);
    check("conflict_err_set", 32'(errv[0]), 32'd1);
    issue(0, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, st, ac);
    idle(4);
    expect_rsp("conflict_word", 0, ac, 32'h00000055, 2);
    check("err_held", 32'(errv[0]), 32'd1);

    // LATENCY=4, MAX_PENDING=2: third read waits for the first retirement
    issue(1, 1'b0, 1'b1, 32'h0, 4'hF, 32'hA1A1A1A1, st, ac);
    issue(1, 1'b0, 1'b1, 32'h4, 4'hF, 32'hB2B2B2B2, st, ac);
    issue(1, 1'b0, 1'b1, 32'h8, 4'hF, 32'hC3C3C3C3, st, ac);
    issue(1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, st, ac1);
    issue(1, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0, st, ac2);
    issue(1, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, st, ac3);
    check("full_stall_cycles", 32'(st), 32'd3);
    check("full_accept_after_retire", 32'(ac3 - ac1), 32'd5);
    idle(8);
    expect_rsp("full_rsp_a", 1, ac1, 32'hA1A1A1A1, 4);
    expect_rsp("full_rsp_b", 1, ac2, 32'hB2B2B2B2, 4);
    expect_rsp("full_rsp_c", 1, ac3, 32'hC3C3C3C3, 4);

    // WAIT_CYCLES=3: every command stalls three cycles
    issue(2, 1'b0, 1'b1, 32'h20, 4'hF, 32'h0BADF00D, st, ac);
    check("wait_write_stalls", 32'(st), 32'd3);
    issue(2, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, st, ac);
    check("wait_read_stalls", 32'(st), 32'd3);
    idle(4);
    expect_rsp("wait_rsp", 2, ac, 32'h0BADF00D, 2);

    // Reset with two reads in flight
    issue(1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, st, ac);
    issue(1, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0, st, ac);
    check("inflight_none_yet", 32'(rsp_q.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_reset_waitrequest", 32'(wreq), 32'h7);
    check("async_reset_readdatavalid", 32'(rdv), 32'h0);
    idle(2);
    check("reset_clears_err", 32'(errv), 32'h0);
    rst_n = 1'b1;
    issue(0, 1'b1, 1'b0, 32'h1010, 4'h0, 32'h0, st, ac);
    check("post_reset_no_stall", 32'(st), 32'd0);
    idle(10);
    expect_rsp("post_reset_alias", 0, ac, 32'hDEADBEEF, 2);
    check("dropped_inflight", 32'(rsp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/avmm_mem_responder.md
AVMM_MEM_RESPONDER -- requirements
Module: avmm_mem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, 10, memory holds 2**DEPTH_LOG2 32-bit words.
REQ-002 Parameter LATENCY, 2, read latency in cycles, legal range 1..8.
REQ-003 Parameter MAX_PENDING, 2, max in-flight reads, legal range 1..LATENCY.
REQ-004 Parameter WAIT_CYCLES, 0, forced wait states per command, legal range 0..7.
REQ-005 clk  input  1  clock; rising edge active.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 address  input  32  byte address; bits [DEPTH_LOG2+1:2] select word, all others ignored.
REQ-008 read  input  1  read command.
REQ-009 write  input  1  write command.
REQ-010 byteenable  input  4  write lane enables; bit n covers writedata[8n+7:8n].
REQ-011 writedata  input  32  write data.
REQ-012 readdata  output  32  read response data, valid only with readdatavalid.
REQ-013 readdatavalid  output  1  one-cycle read response strobe.
REQ-014 waitrequest  output  1  command stall.
REQ-015 err  output  1  sticky protocol-violation flag.

Function
REQ-016 Command accepted in a cycle where (read or write) high and waitrequest low; at most one per cycle.
REQ-017 Command inputs held stable while waitrequest high; responder never samples them then.
REQ-018 waitrequest high = (!rst_n) or (command present and wait counter < WAIT_CYCLES) or (read present and in-flight count == MAX_PENDING).
REQ-019 Wait counter: increments each cycle a command is present and stalled by it; clears on acceptance or when no command present.
REQ-020 WAIT_CYCLES=0 with in-flight < MAX_PENDING: waitrequest low combinationally, command accepted same cycle.
REQ-021 Accepted write updates only byteenable-selected lanes at the accepting clock edge; byteenable=0 writes nothing.
REQ-022 Writes not blocked by full condition.
REQ-023 Accepted read captures word at acceptance edge, including any earlier accepted write.
REQ-024 readdatavalid high exactly LATENCY cycles after acceptance cycle, one cycle per read, strictly in order.
REQ-025 Back-to-back reads yield back-to-back readdatavalid pulses.
REQ-026 In-flight count +1 on read accept, -1 on readdatavalid, unchanged if both same cycle.
REQ-027 Full (count == MAX_PENDING) stalls reads even if a response retires that cycle.
REQ-028 read and write both high: write performed if otherwise acceptable, read dropped (no response), err set.
REQ-029 err once set stays high until reset.
REQ-030 Address beyond memory aliases by ignoring upper bits (wrap-around).

Reset
REQ-031 rst_n low: readdatavalid=0, err=0, waitrequest=1, in-flight=0, wait counter=0, response pipeline cleared, immediately.
REQ-032 Reset mid-operation drops all in-flight reads; no readdatavalid for them after release.
REQ-033 readdata and memory contents not reset.
REQ-034 First command acceptable in first cycle after rst_n deasserts.

Structure
REQ-035 Package avmm_pkg holds data width 32, byteenable width 4, and pipeline-entry struct (valid, data).
REQ-036 Sub-module avmm_rsp_pipe implements LATENCY-stage valid/data shift register.
REQ-037 Memory an inferred synchronous array; no vendor primitives.

Verification
REQ-038 LATENCY=2: write 0xDEADBEEF @0x10 then read @0x10 -> readdatavalid exactly 2 cycles after read accept, readdata 0xDEADBEEF.
REQ-039 Write 0xFFFFFFFF @0x4, write 0x00001234 be=0011 @0x4, read -> 0xFFFF1234.
REQ-040 LATENCY=4, MAX_PENDING=2: 3 consecutive reads -> third stalled until first response, responses in issue order.
REQ-041 WAIT_CYCLES=3: single read -> waitrequest high 3 cycles, accepted 4th cycle, response LATENCY later.
REQ-042 read=write=1 @0x8 data 0x55 -> word written 0x55, no readdatavalid, err=1 held until reset.
REQ-043 Reset asserted with 2 reads in flight -> no readdatavalid after release, err=0, waitrequest=1 during reset; DEPTH_LOG2=10 read @0x1010 returns word @0x10.
